grant_hold_arbiter: RTL and testbench

//  Downstream consumer of the fixed-priority one-hot selector. Samples 8 request lines,

---
 rtl/arb_pkg.sv | 25 ++
 rtl/prio_onehot_sel.sv | 22 ++
 rtl/grant_hold_arbiter.sv | 88 ++++++++
 tb/tb_grant_hold_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and helpers for the grant-hold arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_GAP
  } arb_state_t;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = $clog2(ARB_N);

  // Binary index of the set bit in a one-hot vector; zero for an all-zero vector
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (oh[i]) begin
        idx = idx | i[ARB_IDX_W-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_onehot_sel.sv
// rtl/prio_onehot_sel.sv - combinational fixed-priority one-hot select, highest bit wins
module prio_onehot_sel #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] sel
);

  // Scan from the top bit down and keep only the first request seen
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grant_hold_arbiter.sv
// rtl/grant_hold_arbiter.sv - fixed-priority arbiter holding a registered grant until done, drop or hold limit
module grant_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 timeout
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [N-1:0]     sel;
  logic             normal_release;
  logic             limit_reached;

  prio_onehot_sel #(.N(N)) u_sel (
    .req (req),
    .sel (sel)
  );

  // The grantee finishing or withdrawing always takes precedence over the hold limit
  always_comb begin
    normal_release = done || ((req & grant) == '0);
    limit_reached  = (hold_cnt == CNT_W'(HOLD_MAX - 1));
  end

  // Arbitration FSM: all outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          timeout  <= 1'b0;
          hold_cnt <= '0;
          if (|req) begin
            grant     <= sel;
            gnt_valid <= 1'b1;
            gnt_idx   <= onehot_to_idx(sel);
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (hold_cnt != CNT_W'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (normal_release || limit_reached) begin
            grant     <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= !normal_release;
            state     <= ARB_GAP;
          end
        end
        ARB_GAP: begin
          // One idle bus-turnaround cycle; requests are deliberately not looked at here
          timeout  <= 1'b0;
          hold_cnt <= '0;
          state    <= ARB_IDLE;
        end
        default: begin
          grant     <= '0;
          gnt_valid <= 1'b0;
          gnt_idx   <= '0;
          timeout   <= 1'b0;
          hold_cnt  <= '0;
          state     <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_hold_arbiter.sv
// tb/tb_grant_hold_arbiter.sv - self-checking bench for grant_hold_arbiter
module tb_grant_hold_arbiter;

  localparam int N        = 8;
  localparam int HOLD_MAX = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;

  int n_checks;
  int n_fail;

  grant_hold_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vecs[16];

  // Reference model: who owns the bus, how many cycles it has been visible, pending turnaround
  int m_owner;
  int m_cycles;
  int m_cool;
  logic m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] g, input logic [2:0] ix,
                         input logic v, input logic t);
    chk({name, "_grant"}, 32'(grant), 32'(g));
    chk({name, "_idx"}, 32'(gnt_idx), 32'(ix));
    chk({name, "_valid"}, 32'(gnt_valid), 32'(v));
    chk({name, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_cycles = 0;
    m_cool   = 0;
    m_to     = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        m_owner = -1;
        m_cool  = 1;
        m_to    = 1'b0;
      end else if (m_cycles == HOLD_MAX) begin
        m_owner = -1;
        m_cool  = 1;
        m_to    = 1'b1;
      end else begin
        m_cycles++;
      end
    end else if (m_cool > 0) begin
      m_cool = 0;
      m_to   = 1'b0;
    end else begin
      m_to = 1'b0;
      for (int b = 0; b < N; b++) begin
        if (r[b]) m_owner = b;
      end
      if (m_owner >= 0) m_cycles = 1;
    end
  endtask

  // Drive inputs, take one rising edge, leave time at 1 unit past the edge for sampling
  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] eg;
    logic [2:0] ei;
    n_checks = 0;
    n_fail   = 0;

    // req, done, expected grant, idx, valid, timeout after the edge
    vecs[0]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[2]  = '{8'hA4, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[3]  = '{8'hA4, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{8'hA4, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{8'hA4, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[6]  = '{8'h24, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{8'h24, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{8'h0A, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[13] = '{8'h0B, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[14] = '{8'h03, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[15] = '{8'h03, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

    do_reset();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].req, vecs[i].done);
      chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].valid, vecs[i].to);
    end
    step(8'h03, 1'b0);
    chk_all("vec_tail", 8'h02, 3'd1, 1'b1, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // Hold limit: req[0] held with no done
    step(8'h01, 1'b0);
    chk_all("hold_first", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 2; i <= HOLD_MAX; i++) begin
      step(8'h01, 1'b0);
      chk($sformatf("hold_cyc%0d_valid", i), 32'(gnt_valid), 32'd1);
      chk($sformatf("hold_cyc%0d_timeout", i), 32'(timeout), 32'd0);
    end
    step(8'h01, 1'b0);
    chk_all("hold_forced", 8'h00, 3'd0, 1'b0, 1'b1);
    step(8'h01, 1'b0);
    chk_all("hold_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    step(8'h01, 1'b0);
    chk_all("hold_regrant", 8'h01, 3'd0, 1'b1, 1'b0);

    // done on the very edge the limit would fire: normal release wins
    for (int i = 2; i <= HOLD_MAX; i++) step(8'h01, 1'b0);
    step(8'h01, 1'b1);
    chk_all("limit_done", 8'h00, 3'd0, 1'b0, 1'b0);
    step(8'h00, 1'b0);
    chk_all("limit_done_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-grant
    step(8'h80, 1'b0);
    chk_all("pre_rst", 8'h80, 3'd7, 1'b1, 1'b0);
    step(8'h80, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h01;
    @(posedge clk);
    #1;
    chk_all("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    r = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      logic d;
      if ($urandom_range(0, 9) == 0) r = 8'($urandom);
      if ($urandom_range(0, 29) == 0) r = 8'h00;
      d = ($urandom_range(0, 7) == 0);
      step(r, d);
      model_edge(r, d);
      eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      chk_all($sformatf("rnd%0d", c), eg, ei, m_owner >= 0, m_to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
